// File: rtl/machine_event_fifo.sv
// Captures a {state, timestamp} record on every rising edge of F into a small
// show-ahead FIFO, with a saturating event counter and a sticky overflow flag.
module machine_event_fifo #(
    parameter int DEPTH = 4,
    parameter int TS_W  = 8,
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             F,
    input  logic [2:0]       S,
    input  logic             rd_en,
    output logic [2:0]       dout_state,
    output logic [TS_W-1:0]  dout_ts,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic [CNT_W-1:0] event_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

    logic             f_q;
    logic [TS_W-1:0]  ts_cnt;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      occupancy;
    logic             overflow_q;
    logic [CNT_W-1:0] event_count_q;

    logic [2:0]       mem_state [DEPTH];
    logic [TS_W-1:0]  mem_ts    [DEPTH];

    logic event_det;
    logic rd_ok;
    logic wr_ok;
    logic drop;

    assign empty     = (occupancy == '0);
    assign full      = (occupancy == OCC_FULL);
    assign event_det = F & ~f_q;
    assign rd_ok     = rd_en & ~empty;
    // A read in the same edge frees a slot, so a full FIFO still accepts the write.
    assign wr_ok     = event_det & (~full | rd_ok);
    assign drop      = event_det & ~wr_ok;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            f_q           <= 1'b0;
            ts_cnt        <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            occupancy     <= '0;
            overflow_q    <= 1'b0;
            event_count_q <= '0;
        end else begin
            f_q    <= F;
            ts_cnt <= ts_cnt + TS_W'(1);
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   occupancy <= occupancy + (AW+1)'(1);
                2'b01:   occupancy <= occupancy - (AW+1)'(1);
                default: occupancy <= occupancy;
            endcase
            if (drop) overflow_q <= 1'b1;
            if (event_det && (event_count_q != '1))
                event_count_q <= event_count_q + CNT_W'(1);
        end
    end

    // Storage is intentionally not reset; empty gates the outputs instead.
    always_ff @(posedge CLK) begin
        if (!RESET && wr_ok) begin
            mem_state[wr_ptr] <= S;
            mem_ts[wr_ptr]    <= ts_cnt;
        end
    end

    assign dout_state  = empty ? 3'b000 : mem_state[rd_ptr];
    assign dout_ts     = empty ? '0 : mem_ts[rd_ptr];
    assign overflow    = overflow_q;
    assign event_count = event_count_q;

endmodule

// File: doc/machine_event_fifo.md
Name: machine_event_fifo

Overview:
- Downstream consumer of the JK-based state machine.
- Watches the machine's F output and current-state bus S, and detects each rising edge of F.
- On each detected edge it stores a record {state snapshot, timestamp} in a small FIFO.
- The FIFO is drained through a show-ahead read interface for a later logging or display stage. The block also keeps a saturating total event count and a sticky overflow flag.

Parameters:
- DEPTH, 4: number of FIFO entries. Must be a power of 2, at least 2.
- TS_W, 8: width of the free-running timestamp counter and of the stored timestamp.
- CNT_W, 8: width of the saturating event counter.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- F  input  1  flag output of the upstream state machine.
- S  input  3  current-state bus of the upstream state machine.
- rd_en  input  1  pop request; acts only when empty=0.
- dout_state  output  3  S value stored in the head entry.
- dout_ts  output  TS_W  timestamp stored in the head entry.
- empty  output  1  FIFO holds no entries.
- full  output  1  FIFO holds DEPTH entries.
- overflow  output  1  sticky; an event was dropped.
- event_count  output  CNT_W  total rising edges of F detected, saturating.

Behaviour:
- Clocking and reset:
  - One clock domain. Every register updates on the rising edge of CLK.
  - RESET=1 at an edge clears: f_q, ts_cnt, wr_ptr, rd_ptr, occupancy, overflow, event_count.
  - After reset: empty=1, full=0, overflow=0, event_count=0, dout_state=0, dout_ts=0.
  - The storage array is not cleared. dout_* are defined only while empty=0; with empty=1 they are driven 0.
- Timestamp: ts_cnt increments by 1 at every non-reset edge and wraps from 2^TS_W-1 to 0.
- Event detect:
  - f_q is the registered copy of F.
  - event = F & ~f_q, evaluated with the F value sampled at the current edge.
  - F held high produces exactly one event. F low then high again produces a new event.
  - F already high at the first edge after reset produces an event, because f_q resets to 0.
- Write:
  - On an event edge with space available, store {S, ts_cnt} at wr_ptr, using the pre-increment ts_cnt.
  - Then advance wr_ptr modulo DEPTH and increment occupancy.
  - The entry is visible (empty=0) from the following cycle.
  - Resulting timestamp rule: an event sampled at the n-th edge after RESET falls (n=0 for the first) gets ts = n mod 2^TS_W.
- Read (show-ahead):
  - dout_state and dout_ts continuously show the entry at rd_ptr.
  - rd_en=1 with empty=0 at an edge advances rd_ptr modulo DEPTH and decrements occupancy.
  - rd_en with empty=1 is ignored, with no state change.
- Simultaneous event and rd_en:
  - Not full, not empty: both occur and occupancy is unchanged.
  - Full: the read frees a slot and the write is accepted; no overflow.
  - Empty: the write only; the read is ignored. No fall-through: the new entry appears the next cycle.
- Overflow:
  - An event while full with no accepted read is dropped. FIFO contents and pointers are unchanged.
  - overflow is set to 1 and stays set until RESET.
- event_count increments on every detected event, including dropped ones, and saturates at 2^CNT_W-1.
- Flags:
  - empty = (occupancy==0); full = (occupancy==DEPTH).
  - Both derive from an occupancy register of width log2(DEPTH)+1. Pointers wrap naturally.
- RESET mid-operation: all pending entries are discarded within one edge. An event coinciding with the RESET edge is not recorded and not counted.

Test Plan:
- Reset and idle: hold RESET=1 for 2 edges, then release with F=0 for 5 edges -> empty=1, full=0, overflow=0, event_count=0, dout_state=0, dout_ts=0.
- Single event:
  - Stimulus: release reset; F=1 with S=3'b101 at edge n=3; F stays high for 4 edges.
  - Response: empty=0 from the next cycle, dout_state=101, dout_ts=3, event_count=1 with no further increments while F stays high.
  - Then rd_en for 1 edge -> empty=1.
- Fill and overflow (DEPTH=4):
  - Stimulus: 5 F pulses (1 high, 1 low) with S=1,2,3,4,5 and no reads.
  - Response: after the 4th pulse full=1; the 5th pulse sets overflow=1; event_count=5.
  - Draining 4 entries yields states 1,2,3,4 in order with increasing ts; then empty=1 and overflow stays 1.
- Simultaneous at full: fill to 4, then an F edge with rd_en=1 in the same cycle -> occupancy stays 4, overflow=0, the head advances to entry 2, and the newest entry sits at the tail.
- Read when empty / write when empty: rd_en=1 with empty=1 for 3 edges -> no change. An event with rd_en=1 while empty -> entry stored, empty=0 the next cycle, head holds that event.
- Reset mid-stream and wrap: with 3 entries stored, assert RESET for 1 edge -> empty=1, event_count=0. Run 260 idle edges, then 1 event -> dout_ts = 260 mod 256 = 4.
